uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` byte port between `NUM_PORTS` requesters. Each requester sends packets, marked by `req_last` on the final byte. A grant is held for the whole packet, so bytes from different sources never interleave on the serial line. The block sits between the on-chip byte sources and the `data_in`/`data_in_valid`/`data_in_ready` port of `uart_transmitter`, and holds one registered output byte.

## Interface
- `NUM_PORTS`, default 4: number of requesters; must be ≥ 2.
- `LOCK_TIMEOUT`, default 1024: idle-owner cycles before a lock is revoked. Used only with `UART_ARB_TIMEOUT_EN`.
- `clk`  input  1: single clock.
- `reset`  input  1: asynchronous, active-low reset (asserted when 0).
- `req_data`  input  8*NUM_PORTS: byte of port i on bits [8i+7:8i].
- `req_valid`  input  NUM_PORTS: port i presents a byte.
- `req_last`  input  NUM_PORTS: the presented byte is the last of its packet.
- `req_ready`  output  NUM_PORTS: byte of port i accepted this cycle when valid & ready.
- `tx_data`  output  8: to `uart_transmitter.data_in`.
- `tx_valid`  output  1: to `data_in_valid`.
- `tx_ready`  input  1: from `data_in_ready`.
- `grant_id`  output  $clog2(NUM_PORTS): current or most recent owner.
- `busy`  output  1: high while in LOCKED.
- `timeout_pulse`  output  1: one-cycle pulse when a lock is revoked.

## Operation
- FSM with two states: IDLE and LOCKED.
- IDLE:
  - If any `req_valid` bit is high, select the first set bit searching upward from `ptr+1` modulo `NUM_PORTS`.
  - Load that index into `grant_id` and go to LOCKED on the next edge.
  - `req_ready` is all zeros in IDLE.
- LOCKED:
  - `req_ready[grant_id] = (!tx_valid || tx_ready)`; all other bits are 0.
  - On an accept (valid & ready), the byte is written to the output register and `tx_valid` is set.
  - An accept with `req_last` high moves the FSM to IDLE and sets `ptr <= grant_id`.
- Output register:
  - `tx_valid` clears when `tx_ready` is high and no new byte is accepted in the same cycle.
  - Simultaneous drain and accept keeps `tx_valid` high and loads the new byte (full throughput).
  - `tx_data` and `tx_valid` are stable while `tx_valid && !tx_ready`.
- Requester rules: a requester must hold `req_valid`, `req_data` and `req_last` stable until accepted. Deasserting `req_valid` in IDLE before a grant is legal; the arbiter then re-arbitrates on current inputs.
- Grants do not depend on `tx_ready`. A packet can be granted while the previous packet's last byte is still in the output register.

## Timing
- Reset values:
  - `tx_valid` = 0, `tx_data` = 0, `req_ready` = 0, `busy` = 0, `timeout_pulse` = 0.
  - `grant_id` = 0, `ptr` = NUM_PORTS-1 (port 0 has first priority), FSM in IDLE.
- Reset asserted mid-packet immediately clears all state. The byte in the output register is dropped, and the owner's packet is truncated.
- Arbitration takes one cycle: valid seen in IDLE at edge t, `req_ready` high during cycle t+1.
- Accept-to-`tx_valid` latency is 1 cycle.
- With continuous `tx_ready`, a packet of B bytes streams at 1 byte per cycle. One bubble cycle follows each packet for the IDLE arbitration.
- A single-byte packet (`req_last` on the first byte) returns to IDLE after 1 accept.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(LOCK_TIMEOUT+1) runs in LOCKED.
  - It increments each cycle the owner's `req_valid` is low and clears on every accept and on entering LOCKED.
  - When the count reaches `LOCK_TIMEOUT`: go to IDLE, set `ptr <= grant_id`, pulse `timeout_pulse` for exactly 1 cycle.
  - The byte already in the output register still drains normally.
  - A timeout and an accept cannot coincide, because the counter only advances while `req_valid` is low.
- Undefined:
  - No counter is built.
  - A lock is held until a `req_last` accept, indefinitely if needed.
  - `timeout_pulse` is tied to 0 and `LOCK_TIMEOUT` is ignored.

## Test plan
- Reset, then port 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with `tx_ready`=1 -> `grant_id`=2; `tx_data` 0x41,0x42,0x43 on consecutive cycles, first one 2 cycles after `req_valid` rises; `busy` falls after 0x43 is accepted.
- Ports 0,1,3 all valid continuously with 2-byte packets -> grant order 0,1,3,0,1,3; bytes never interleave within a packet.
- Port 1 mid-packet while port 0 is requesting, `tx_ready` held low 20 cycles -> `tx_data` stable, `req_ready` low for 20 cycles; port 0 is not granted until port 1's last byte is accepted.
- `tx_ready` toggling 1,0,1,0 during a 4-byte packet -> every byte appears exactly once, in order, with no duplication.
- `UART_ARB_TIMEOUT_EN`, `LOCK_TIMEOUT`=16: port 0 sends 1 non-last byte then drops valid -> `timeout_pulse` 16 cycles after the accept; a pending port 1 is granted the following arbitration cycle.
- Reset asserted while `tx_valid`=1 mid-packet -> `tx_valid`, `req_ready` and `busy` go 0 without waiting for a clock edge; after release, port 0 has priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one uart_transmitter byte port between
//   NUM_PORTS packet sources. A grant is held from the first byte of a packet
//   until its req_last byte is accepted, so packets never interleave. One
//   registered output byte (tx_data/tx_valid) feeds the transmitter.
//
// Parameters
//   NUM_PORTS    number of requesters (>= 2)
//   LOCK_TIMEOUT idle-owner cycles before a lock is revoked (timeout build only)
//
// Ports
//   clk            single clock
//   reset          asynchronous reset, active low
//   req_data       byte of port i on [8i+7:8i]
//   req_valid      port i presents a byte
//   req_last       presented byte ends the packet
//   req_ready      byte of port i accepted when valid & ready
//   tx_data        byte to uart_transmitter.data_in
//   tx_valid       to data_in_valid
//   tx_ready       from data_in_ready
//   grant_id       current or most recent owner
//   busy           high while a lock is held
//   timeout_pulse  one-cycle pulse when a lock is revoked
//
// Build option
//   UART_ARB_TIMEOUT_EN  when defined, a lock whose owner leaves req_valid low
//                        for LOCK_TIMEOUT cycles is revoked. Otherwise a lock
//                        is held until the req_last accept and timeout_pulse
//                        is tied low.
module uart_tx_arbiter #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [8*NUM_PORTS-1:0]       req_data,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS-1:0]         req_last,
  output logic [NUM_PORTS-1:0]         req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         timeout_pulse
);

  localparam int unsigned IDW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_PORTS must be >= 2 and LOCK_TIMEOUT >= 1");
  end

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cand_id;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           out_free;
  logic           accept;
  logic           found;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tpulse_q, tpulse_d;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    req_ready = '0;
    found     = 1'b0;
    cand_id   = '0;
    accept    = 1'b0;
    // The output register can take a byte when empty or draining this cycle.
    out_free  = !valid_q || tx_ready;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tpulse_d  = 1'b0;
`endif

    if (valid_q && tx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Search upward from ptr+1, wrapping, for the first requesting port.
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
          cand_id = IDW'((32'(ptr_q) + i) % NUM_PORTS);
          if (!found && req_valid[cand_id]) begin
            found   = 1'b1;
            grant_d = cand_id;
          end
        end
        if (found) begin
          state_d = S_LOCKED;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_LOCKED: begin
        req_ready[grant_q] = out_free;
        accept             = req_valid[grant_q] && out_free;
        if (accept) begin
          // A simultaneous drain and accept overrides the clear above.
          data_d  = req_data[{grant_q, 3'b000} +: 8];
          valid_d = 1'b1;
          if (req_last[grant_q]) begin
            state_d = S_IDLE;
            ptr_d   = grant_q;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (accept) begin
          cnt_d = '0;
        end else if (!req_valid[grant_q]) begin
          // Revoke on the edge where the idle count reaches LOCK_TIMEOUT.
          if (32'(cnt_q) + 1 == LOCK_TIMEOUT) begin
            state_d  = S_IDLE;
            ptr_d    = grant_q;
            tpulse_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = CW'(32'(cnt_q) + 1);
          end
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= IDW'(NUM_PORTS - 1);
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      tpulse_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tpulse_q <= tpulse_d;
`endif
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == S_LOCKED);

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_pulse = tpulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-port packet queues drive the requesters,
// a transaction-level scoreboard checks grant order, packet atomicity and the
// output byte stream, and directed steps pin exact cycle timing.
module tb_uart_tx_arbiter;

  localparam int NP = 4;
  localparam int LT = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [8*NP-1:0] req_data = '0;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0]   req_last = '0;
  logic [NP-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_pulse;

  uart_tx_arbiter #(
    .NUM_PORTS   (NP),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [8:0]  pq [NP][$];     // {last, data} per requester
  logic [7:0]  exp_tx [$];     // bytes the transmitter must still see, in order
  int          exp_grant [$];  // hand-computed owner order of packets
  logic [NP-1:0] acc_s = '0;
  logic        in_pkt = 1'b0;
  int          owner = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [NP-1:0] rr_exp;
  logic        rdy_next = 1'b1;
  logic        ready_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual %0h, required nothing", name, act);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) pq[p].push_back({(k == n - 1), 8'(base + k)});
  endtask

  function automatic logic pending();
    logic r = 1'b0;
    for (int i = 0; i < NP; i++) if (pq[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NP; i++) pq[i].delete();
    exp_tx.delete();
    exp_grant.delete();
    in_pkt = 1'b0;
    acc_s  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pending() || busy || tx_valid || exp_tx.size() != 0) && n < budget) begin
      nclk(1);
      n++;
    end
    chk({name, "_drain_in_budget"}, 32'(n < budget), 1);
    chk({name, "_grants_used"}, exp_grant.size(), 0);
  endtask

  // Requester engine and tx_ready source: all inputs change just after posedge.
  always begin
    logic [8:0] tmp;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (acc_s[i] && pq[i].size() != 0) tmp = pq[i].pop_front();
    tx_ready = ready_toggle ? !tx_ready : rdy_next;
    for (int i = 0; i < NP; i++) begin
      if (pq[i].size() != 0) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[8*i +: 8]} = pq[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[8*i +: 8] = '0;
      end
    end
  end

  // Scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      acc_s      = '0;
      prev_stall = 1'b0;
    end else begin
      rr_exp = '0;
      if (busy) rr_exp[grant_id] = !tx_valid || tx_ready;
      chk("req_ready_rule", 32'(req_ready), 32'(rr_exp));

      if (prev_stall) begin
        chk("stall_valid", 32'(tx_valid), 1);
        chk("stall_data", 32'(tx_data), 32'(prev_data));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;

      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) fail_now("tx_extra_byte", 32'(tx_data));
        else chk("tx_byte_order", 32'(tx_data), 32'(exp_tx.pop_front()));
      end

      if (timeout_pulse) in_pkt = 1'b0;

      acc_s = req_valid & req_ready;
      for (int i = 0; i < NP; i++) begin
        if (acc_s[i]) begin
          if (!in_pkt) begin
            if (exp_grant.size() == 0) fail_now("grant_extra", i);
            else chk("grant_order", i, exp_grant.pop_front());
            in_pkt = 1'b1;
            owner  = i;
          end else begin
            chk("no_interleave", i, owner);
          end
          exp_tx.push_back(req_data[8*i +: 8]);
          if (req_last[i]) in_pkt = 1'b0;
        end
      end
    end
  end

  initial begin
    // Reset values
    nclk(2);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout_pulse), 0);
    chk("rst_grant", 32'(grant_id), 0);
    #2 reset = 1'b1;
    nclk(1);

    // Port 2, three bytes, tx_ready high
    push(2, 8'h41, 3);
    exp_grant.push_back(2);
    nclk(1);
    chk("t1_arb_busy", 32'(busy), 0);
    chk("t1_arb_ready", 32'(req_ready), 0);
    nclk(1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_grant", 32'(grant_id), 2);
    chk("t1_ready", 32'(req_ready), 32'h4);
    nclk(1);
    chk("t1_valid0", 32'(tx_valid), 1);
    chk("t1_byte0", 32'(tx_data), 32'h41);
    nclk(1);
    chk("t1_byte1", 32'(tx_data), 32'h42);
    nclk(1);
    chk("t1_byte2", 32'(tx_data), 32'h43);
    chk("t1_busy_fall", 32'(busy), 0);
    nclk(1);
    chk("t1_valid_clear", 32'(tx_valid), 0);
    drain("t1", 50);

    // Ports 0,1,3 with two 2-byte packets each, from reset priority
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push(0, 8'(8'h00 + 2 * r), 2);
      push(1, 8'(8'h10 + 2 * r), 2);
      push(3, 8'(8'h30 + 2 * r), 2);
    end
    exp_grant = '{0, 1, 3, 0, 1, 3};
    nclk(2);
    chk("t2_first_grant", 32'(grant_id), 0);
    chk("t2_first_busy", 32'(busy), 1);
    drain("t2", 100);

    // Port 1 stalled by tx_ready low while port 0 waits
    rdy_next = 1'b0;
    push(1, 8'h10, 3);
    exp_grant = '{1, 0};
    nclk(2);
    chk("t3_grant", 32'(grant_id), 1);
    chk("t3_ready", 32'(req_ready), 32'h2);
    nclk(1);
    push(0, 8'h20, 1);
    for (int k = 0; k < 20; k++) begin
      chk("t3_hold_data", 32'(tx_data), 32'h10);
      chk("t3_hold_valid", 32'(tx_valid), 1);
      chk("t3_hold_ready", 32'(req_ready), 0);
      chk("t3_hold_grant", 32'(grant_id), 1);
      chk("t3_no_timeout", 32'(timeout_pulse), 0);
      nclk(1);
    end
    rdy_next = 1'b1;
    drain("t3", 60);

    // Toggling tx_ready during a 4-byte packet
    push(2, 8'hA0, 4);
    exp_grant.push_back(2);
    ready_toggle = 1'b1;
    drain("t4", 60);
    ready_toggle = 1'b0;
    rdy_next     = 1'b1;
    nclk(2);

    // Owner drops valid after one non-last byte
    pq[0].push_back({1'b0, 8'h55});
    push(1, 8'h66, 1);
    exp_grant = '{0, 1};
    nclk(2);
    chk("t5_grant0", 32'(grant_id), 0);
`ifdef UART_ARB_TIMEOUT_EN
    nclk(16);
    chk("t5_pre_pulse", 32'(timeout_pulse), 0);
    chk("t5_pre_busy", 32'(busy), 1);
    nclk(1);
    chk("t5_pulse", 32'(timeout_pulse), 1);
    chk("t5_pulse_busy", 32'(busy), 0);
    nclk(1);
    chk("t5_pulse_once", 32'(timeout_pulse), 0);
    chk("t5_regrant", 32'(grant_id), 1);
    chk("t5_regrant_busy", 32'(busy), 1);
`else
    nclk(40);
    chk("t5_still_locked", 32'(busy), 1);
    chk("t5_still_owner", 32'(grant_id), 0);
    chk("t5_no_pulse", 32'(timeout_pulse), 0);
    push(0, 8'h56, 1);
`endif
    drain("t5", 80);

    // Asynchronous reset mid-packet with a byte held in the output register
    rdy_next = 1'b0;
    push(3, 8'hC0, 4);
    exp_grant.push_back(3);
    nclk(3);
    chk("t6_pre_valid", 32'(tx_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(tx_valid), 0);
    chk("t6_async_ready", 32'(req_ready), 0);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_data", 32'(tx_data), 0);
    clear_model();
    rdy_next = 1'b1;
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    push(3, 8'hD0, 1);
    push(0, 8'hE0, 1);
    exp_grant = '{0, 3};
    nclk(1);
    chk("t6_arb_busy", 32'(busy), 0);
    nclk(1);
    chk("t6_port0_first", 32'(grant_id), 0);
    drain("t6", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
